// File: rtl/adc_frame_packer.sv
// Reassembles gated serial ADC samples into frames and emits committed frames as bytes.
// A staging buffer with speculative/commit pointers keeps partial frames from the host.
module adc_frame_packer #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned OUT_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_sync,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [7:0]  out_data,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [15:0] frame_count,
    output logic [15:0] overflow_count,
    output logic        framing_err,
    output logic        busy
);

    localparam int unsigned BYTES       = SAMPLE_BITS / 8;
    localparam int unsigned FRAME_BYTES = CHANNELS * BYTES;
    localparam int unsigned AW          = $clog2(OUT_DEPTH);
    localparam int unsigned PW          = AW + 1;
    localparam int unsigned CW          = $clog2(SAMPLE_BITS + 2);
    localparam int unsigned IW          = $clog2(CHANNELS + 1);
    localparam int unsigned SW          = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        COLLECT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] ser_q, ser_d;
    logic [SW-1:0]          ser_cnt_q, ser_cnt_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]          ch_idx_q, ch_idx_d;
    logic                   commit_pend_q, commit_pend_d;
    logic [PW-1:0]          wr_spec_q, wr_spec_d;
    logic [PW-1:0]          wr_commit_q, wr_commit_d;
    logic [PW-1:0]          rd_q, rd_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [15:0]            ovf_cnt_q, ovf_cnt_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   out_wr_en_q, out_wr_en_d;
    logic [7:0]             mem_q [OUT_DEPTH];
    logic [PW-1:0]          used, free;
    logic                   rollback;

    // Space check sees the post-rollback view, so committed data only.
    assign used = wr_commit_q - rd_q;
    assign free = PW'(OUT_DEPTH) - used;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        ser_d         = ser_q;
        ser_cnt_d     = ser_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        ch_idx_d      = ch_idx_q;
        commit_pend_d = commit_pend_q;
        wr_spec_d     = wr_spec_q;
        wr_commit_d   = wr_commit_q;
        frame_cnt_d   = frame_cnt_q;
        ovf_cnt_d     = ovf_cnt_q;
        err_d         = err_q;
        rollback      = 1'b0;

        if (ser_cnt_q != '0) begin
            ser_d     = ser_q << 8;
            ser_cnt_d = ser_cnt_q - SW'(1);
            wr_spec_d = wr_spec_q + PW'(1);
        end

        if (frame_sync) begin
            if (state_q == COLLECT && ch_idx_q < IW'(CHANNELS)) begin
                err_d = 1'b1;
            end
            rollback = 1'b1;
            if (!enable) begin
                state_d = IDLE;
            end else if (free >= PW'(FRAME_BYTES)) begin
                state_d = COLLECT;
            end else begin
                state_d = HUNT;
                if (ovf_cnt_q != 16'hFFFF) begin
                    ovf_cnt_d = ovf_cnt_q + 16'd1;
                end
            end
        end else if (state_q == COLLECT) begin
            if (!enable) begin
                rollback = 1'b1;
                state_d  = IDLE;
            end else if (commit_pend_q) begin
                if (ser_cnt_q == '0) begin
                    wr_commit_d   = wr_spec_q;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                    commit_pend_d = 1'b0;
                    state_d       = IDLE;
                end
            end else if (bit_valid) begin
                if (bit_cnt_q == CW'(SAMPLE_BITS)) begin
                    err_d    = 1'b1;
                    rollback = 1'b1;
                    state_d  = HUNT;
                end else begin
                    shift_d   = {shift_q[SAMPLE_BITS-2:0], bit_in};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end else if (bit_cnt_q != '0) begin
                // Burst end: hand a complete sample to the serializer.
                if (bit_cnt_q == CW'(SAMPLE_BITS)) begin
                    ser_d     = shift_q;
                    ser_cnt_d = SW'(BYTES);
                    bit_cnt_d = '0;
                    ch_idx_d  = ch_idx_q + IW'(1);
                    if (ch_idx_q == IW'(CHANNELS - 1)) begin
                        commit_pend_d = 1'b1;
                    end
                end else begin
                    err_d    = 1'b1;
                    rollback = 1'b1;
                    state_d  = HUNT;
                end
            end
        end

        if (rollback) begin
            wr_spec_d     = wr_commit_q;
            ser_cnt_d     = '0;
            commit_pend_d = 1'b0;
            bit_cnt_d     = '0;
            ch_idx_d      = '0;
        end

        busy_d = (state_d == COLLECT) || (ser_cnt_d != '0);
    end

    // Drain side: only committed bytes, one per cycle when the FIFO has room.
    always_comb begin
        rd_d        = rd_q;
        out_wr_en_d = 1'b0;
        out_data_d  = out_data_q;
        if (rd_q != wr_commit_q && !out_full) begin
            out_wr_en_d = 1'b1;
            out_data_d  = mem_q[rd_q[AW-1:0]];
            rd_d        = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            ser_q         <= '0;
            ser_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            ch_idx_q      <= '0;
            commit_pend_q <= 1'b0;
            wr_spec_q     <= '0;
            wr_commit_q   <= '0;
            rd_q          <= '0;
            frame_cnt_q   <= '0;
            ovf_cnt_q     <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            out_data_q    <= '0;
            out_wr_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            ser_q         <= ser_d;
            ser_cnt_q     <= ser_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            ch_idx_q      <= ch_idx_d;
            commit_pend_q <= commit_pend_d;
            wr_spec_q     <= wr_spec_d;
            wr_commit_q   <= wr_commit_d;
            rd_q          <= rd_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            out_data_q    <= out_data_d;
            out_wr_en_q   <= out_wr_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ser_cnt_q != '0) begin
            mem_q[wr_spec_q[AW-1:0]] <= ser_q[SAMPLE_BITS-1 -: 8];
        end
    end

    assign out_data       = out_data_q;
    assign out_wr_en      = out_wr_en_q;
    assign frame_count    = frame_cnt_q;
    assign overflow_count = ovf_cnt_q;
    assign framing_err    = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: drives serial bursts, collects emitted bytes, checks against hand values.
module tb_adc_frame_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_sync;
    logic        bit_in;
    logic        bit_valid;
    logic [7:0]  out_data;
    logic        out_wr_en;
    logic        out_full;
    logic [15:0] frame_count;
    logic [15:0] overflow_count;
    logic        framing_err;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [7:0]  got_q [$];
    int          got_cyc_q [$];
    logic [7:0]  exp_q [$];

    adc_frame_packer #(
        .SAMPLE_BITS(16),
        .CHANNELS   (3),
        .OUT_DEPTH  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .frame_sync    (frame_sync),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .out_data      (out_data),
        .out_wr_en     (out_wr_en),
        .out_full      (out_full),
        .frame_count   (frame_count),
        .overflow_count(overflow_count),
        .framing_err   (framing_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte capture away from the active edge.
    always @(negedge clk) begin
        if (out_wr_en) begin
            got_q.push_back(out_data);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic send_burst(input logic [31:0] val, input int nbits, input int gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = val[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_frame(input string tag);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < 300) begin
            tick();
            k++;
        end
        repeat (20) tick();
        check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check_eq($sformatf("%s_b%0d", tag, i),
                     (i < got_q.size()) ? 32'(got_q[i]) : 32'h1FF, 32'(exp_q[i]));
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        frame_sync = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        out_full   = 1'b0;
        repeat (3) tick();
        check_eq("rst_wr_en", 32'(out_wr_en), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_fcnt", 32'(frame_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow_count), 32'd0);
        check_eq("rst_err", 32'(framing_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Good frame, bytes only after commit, back to back.
        enable = 1'b1;
        got_q.delete(); got_cyc_q.delete();
        pulse_sync();
        send_burst(32'hA5C3, 16, 16);
        send_burst(32'h1234, 16, 16);
        send_burst(32'hFFFF, 16, 0);
        check_eq("t1_no_early_bytes", 32'(got_q.size()), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        exp_q = '{8'hA5, 8'hC3, 8'h12, 8'h34, 8'hFF, 8'hFF};
        check_frame("t1");
        check_eq("t1_consecutive",
                 (got_cyc_q.size() == 6) ? 32'(got_cyc_q[5] - got_cyc_q[0]) : 32'hFFFF, 32'd5);
        check_eq("t1_fcnt", 32'(frame_count), 32'd1);
        check_eq("t1_err", 32'(framing_err), 32'd0);
        check_eq("t1_ovf", 32'(overflow_count), 32'd0);
        check_eq("t1_idle_busy", 32'(busy), 32'd0);

        // Held-off FIFO: second frame has no room and is dropped.
        got_q.delete(); got_cyc_q.delete();
        out_full = 1'b1;
        pulse_sync();
        send_burst(32'h1111, 16, 16);
        send_burst(32'h2222, 16, 16);
        send_burst(32'h3333, 16, 16);
        check_eq("t2_fcnt_a", 32'(frame_count), 32'd2);
        pulse_sync();
        check_eq("t2_ovf", 32'(overflow_count), 32'd1);
        send_burst(32'h4444, 16, 16);
        send_burst(32'h5555, 16, 16);
        send_burst(32'h6666, 16, 16);
        check_eq("t2_held", 32'(got_q.size()), 32'd0);
        out_full = 1'b0;
        exp_q = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        check_frame("t2");
        check_eq("t2_fcnt_b", 32'(frame_count), 32'd2);

        // Short burst aborts the frame; the next frame goes through.
        got_q.delete(); got_cyc_q.delete();
        pulse_sync();
        send_burst(32'h0BAD, 16, 16);
        send_burst(32'h1234, 15, 30);
        check_eq("t3_err", 32'(framing_err), 32'd1);
        check_eq("t3_no_bytes", 32'(got_q.size()), 32'd0);
        pulse_sync();
        send_burst(32'h0001, 16, 16);
        send_burst(32'h0002, 16, 16);
        send_burst(32'h0003, 16, 16);
        exp_q = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
        check_frame("t3");
        check_eq("t3_fcnt", 32'(frame_count), 32'd3);

        // Reset mid-burst clears everything.
        got_q.delete(); got_cyc_q.delete();
        pulse_sync();
        send_burst(32'h1357, 16, 16);
        for (int i = 15; i >= 8; i--) begin
            bit_valid = 1'b1;
            bit_in    = 1'(32'h2468 >> i);
            tick();
        end
        reset     = 1'b1;
        bit_valid = 1'b0;
        tick();
        check_eq("t5_wr_en", 32'(out_wr_en), 32'd0);
        check_eq("t5_data", 32'(out_data), 32'd0);
        check_eq("t5_fcnt", 32'(frame_count), 32'd0);
        check_eq("t5_ovf", 32'(overflow_count), 32'd0);
        check_eq("t5_err", 32'(framing_err), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check_eq("t5_empty", 32'(got_q.size()), 32'd0);
        pulse_sync();
        send_burst(32'h2468, 16, 16);
        send_burst(32'hACE0, 16, 16);
        send_burst(32'h1F2E, 16, 16);
        exp_q = '{8'h24, 8'h68, 8'hAC, 8'hE0, 8'h1F, 8'h2E};
        check_frame("t5");
        check_eq("t5_fcnt_b", 32'(frame_count), 32'd1);

        // Early frame_sync: partial frame rolled back, new frame completes.
        got_q.delete(); got_cyc_q.delete();
        pulse_sync();
        send_burst(32'hDEAD, 16, 16);
        send_burst(32'hBEEF, 16, 16);
        pulse_sync();
        check_eq("t4_err", 32'(framing_err), 32'd1);
        send_burst(32'hCAFE, 16, 16);
        send_burst(32'h0102, 16, 16);
        send_burst(32'h8001, 16, 16);
        exp_q = '{8'hCA, 8'hFE, 8'h01, 8'h02, 8'h80, 8'h01};
        check_frame("t4");
        check_eq("t4_fcnt", 32'(frame_count), 32'd2);

        // Disabled acquisition: nothing happens.
        got_q.delete(); got_cyc_q.delete();
        enable = 1'b0;
        pulse_sync();
        check_eq("t6_busy", 32'(busy), 32'd0);
        send_burst(32'h5555, 16, 16);
        send_burst(32'h5555, 16, 16);
        send_burst(32'h5555, 16, 30);
        check_eq("t6_no_bytes", 32'(got_q.size()), 32'd0);
        check_eq("t6_fcnt", 32'(frame_count), 32'd2);
        check_eq("t6_ovf", 32'(overflow_count), 32'd0);
        check_eq("t6_err", 32'(framing_err), 32'd1);
        check_eq("t6_busy_end", 32'(busy), 32'd0);

        // Overlong burst (17 bits) is a framing error.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        pulse_sync();
        send_burst(32'h1FFFF, 17, 0);
        check_eq("t7_err", 32'(framing_err), 32'd1);
        check_eq("t7_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        check_eq("t7_fcnt", 32'(frame_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
